// File: rtl/mux32_1_if.sv
// Bus bundle for the 32:1 bit selector: candidate word, select index,
// combinational result and its registered copy.
interface mux32_1_if;
  logic [31:0] in;
  logic [4:0]  sel;
  logic        out;
  logic        out_q;

  modport master (output in, output sel, input out, input out_q);
  modport slave  (input in, input sel, output out, output out_q);
endinterface

// File: rtl/mux32_1.sv
// 32:1 bit selector built as a 5-level tree of gate-level 2:1 stages,
// with a registered copy of the result behind a synchronous active-low reset.
module mux32_1 #(
  parameter int DELAY = 50
) (
  input  logic    clk,
  input  logic    rst_n,
  mux32_1_if.slave bus
);

  // Heap-ordered tree: node 0 is the root, nodes 31..62 are the leaves in[0..31].
  // The children of node i are 2i+1 (lower candidate) and 2i+2 (upper candidate).
  logic [62:0] node;

  assign node[62:31] = bus.in;

  for (genvar i = 0; i < 31; i++) begin : g_stage
    // Leaf-adjacent stages (i = 15..30) use sel[0]; the root uses sel[4].
    localparam int LVL = 5 - $clog2(i + 2);
    logic s_n;
    logic a0;
    logic a1;

    assign #(DELAY) s_n     = ~bus.sel[LVL];
    assign #(DELAY) a0      = node[2*i+1] & s_n;
    assign #(DELAY) a1      = node[2*i+2] & bus.sel[LVL];
    assign #(DELAY) node[i] = a0 | a1;
  end

  assign bus.out = node[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_q <= '0;
    end else begin
      bus.out_q <= bus.out;
    end
  end

endmodule

// File: tb/tb_mux32_1.sv
// Scoreboard bench for mux32_1: stimulus pushes expected (out, out_q) per cycle,
// a negedge monitor pops and compares once the tree has settled.
module tb_mux32_1;
  localparam int TB_DELAY = 4;   // settle bound 15*4 = 60 < half period
  localparam int HALF     = 100;

  logic clk;
  logic rst_n;
  mux32_1_if bus ();

  mux32_1 #(.DELAY(TB_DELAY)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #(HALF) clk = ~clk;

  typedef struct {
    logic        exp_out;
    logic        exp_q;
    logic [31:0] in_v;
    logic [4:0]  sel_v;
    string       tag;
  } item_t;

  item_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  logic  cur_exp;
  bit    done = 1'b0;

  // One cycle of stimulus: the edge captures the previous vector, then new inputs apply.
  task automatic step(input logic [31:0] i, input logic [4:0] s, input logic r,
                      input logic e, input string tag);
    item_t it;
    @(posedge clk);
    it.exp_q   = (rst_n == 1'b0) ? 1'b0 : cur_exp;
    #1;
    bus.in     = i;
    bus.sel    = s;
    rst_n      = r;
    cur_exp    = e;
    it.exp_out = e;
    it.in_v    = i;
    it.sel_v   = s;
    it.tag     = tag;
    sb.push_back(it);
  endtask

  always @(negedge clk) begin
    item_t it;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      checks++;
      if (bus.out !== it.exp_out) begin
        failures++;
        $display("FAIL %s out: in=%h sel=%0d got=%b want=%b",
                 it.tag, it.in_v, it.sel_v, bus.out, it.exp_out);
      end
      checks++;
      if (bus.out_q !== it.exp_q) begin
        failures++;
        $display("FAIL %s out_q: in=%h sel=%0d got=%b want=%b",
                 it.tag, it.in_v, it.sel_v, bus.out_q, it.exp_q);
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [31:0] ri;
    logic [4:0]  rs;
    rst_n   = 1'b0;
    bus.in  = 32'hFFFF_FFFF;
    bus.sel = 5'd0;
    cur_exp = 1'b1;

    // Reset held for two edges with all-ones input: out=1, out_q=0
    step(32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1, "rst_hold");
    step(32'hFFFF_FFFF, 5'd7, 1'b1, 1'b1, "rst_release");
    step(32'hFFFF_FFFF, 5'd7, 1'b1, 1'b1, "first_load");
    // One-edge latency on out_q after input/select changes
    step(32'h0000_0000, 5'd7, 1'b1, 1'b0, "lat_in");
    step(32'h0000_0080, 5'd7, 1'b1, 1'b1, "lat_set");
    step(32'h0000_0080, 5'd6, 1'b1, 1'b0, "lat_sel");

    // Sel sweep on alternating pattern: out = sel[0]
    for (int s = 0; s < 32; s++) begin
      step(32'hAAAA_AAAA, 5'(s), 1'b1, 1'(s % 2), "sweep");
    end

    // Extremes
    step(32'h8000_0001, 5'd0,  1'b1, 1'b1, "ext_lo");
    step(32'h8000_0001, 5'd31, 1'b1, 1'b1, "ext_hi");
    step(32'h8000_0001, 5'd16, 1'b1, 1'b0, "ext_mid");

    // Timing: 0 -> 1 transition settles before the negedge sample and holds
    step(32'hFFFF_0000, 5'd0,  1'b1, 1'b0, "tim_0");
    step(32'hFFFF_0000, 5'd31, 1'b1, 1'b1, "tim_31");
    step(32'hFFFF_0000, 5'd31, 1'b1, 1'b1, "tim_hold");

    // Walking one
    for (int k = 0; k < 32; k++) begin
      w = 32'd1 << k;
      for (int s = 0; s < 32; s++) begin
        step(w, 5'(s), 1'b1, (s == k) ? 1'b1 : 1'b0, "walk");
      end
    end

    // Reset asserted mid-operation clears out_q while out keeps tracking
    step(32'hFFFF_FFFF, 5'd3, 1'b1, 1'b1, "mid_pre");
    step(32'hFFFF_FFFF, 5'd3, 1'b0, 1'b1, "mid_rst");
    step(32'h0000_0008, 5'd3, 1'b0, 1'b1, "mid_rst2");
    step(32'h0000_0008, 5'd3, 1'b1, 1'b1, "mid_rel");
    step(32'h0000_0008, 5'd2, 1'b1, 1'b0, "mid_load");

    // Random pairs with simultaneous in/sel changes
    for (int n = 0; n < 1000; n++) begin
      ri = $urandom;
      rs = 5'($urandom_range(0, 31));
      step(ri, rs, 1'b1, ri[rs], "rand");
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    done = 1'b1;
    $finish;
  end

  initial begin
    #(2 * HALF * 5000);
    if (!done) begin
      $display("FAIL timeout: finished=0 want=1");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
    end
  end

endmodule
